// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, counter types and sync helper
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W    = 10;
  localparam int FRAME_W  = 8;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Maps a logical "sync active" flag onto the connector level.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing bundle from the generator to the renderer and connector
interface vga_timing_if;
  import vga_pkg::*;

  cnt_t   h_cnt;
  cnt_t   v_cnt;
  logic   VGAvalid;
  logic   hsync;
  logic   vsync;
  logic   line_start;
  logic   frame_start;
  frame_t frame_cnt;

  modport master (
    output h_cnt, v_cnt, VGAvalid, hsync, vsync, line_start, frame_start, frame_cnt
  );

  modport slave (
    input h_cnt, v_cnt, VGAvalid, hsync, vsync, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/sync_window.sv
// rtl/sync_window.sv - combinational decode of one axis count into active and sync windows
module sync_window
  import vga_pkg::*;
#(
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751
) (
  input  cnt_t cnt,
  output logic in_active,
  output logic in_sync
);

  localparam cnt_t ACT_LIM  = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_LO  = cnt_t'(SYNC_START);
  localparam cnt_t SYNC_HI  = cnt_t'(SYNC_END);

  assign in_active = (cnt < ACT_LIM);
  assign in_sync   = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel/line counters with aligned syncs, pulses and frame count
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       en,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam vga_pkg::cnt_t H_LAST = vga_pkg::cnt_t'(H_TOTAL - 1);
  localparam vga_pkg::cnt_t V_LAST = vga_pkg::cnt_t'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  vga_pkg::cnt_t   h_cnt, v_cnt, h_nxt, v_nxt;
  vga_pkg::frame_t frame_cnt;
  logic            h_wrap, frame_wrap;
  logic            h_act, v_act, h_sync_nxt, v_sync_nxt;
  logic            valid, hs_pre, vs_pre, hsync, vsync, line_start, frame_start;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    frame_wrap = h_wrap && (v_nxt == '0);
  end

  // Both axes are decoded from the next-state counts so VGAvalid lands with the counters.
  sync_window #(
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC - 1)
  ) u_h_window (
    .cnt       (h_nxt),
    .in_active (h_act),
    .in_sync   (h_sync_nxt)
  );

  sync_window #(
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC - 1)
  ) u_v_window (
    .cnt       (v_nxt),
    .in_active (v_act),
    .in_sync   (v_sync_nxt)
  );

  // hs_pre/vs_pre track the current counts; the second stage adds the renderer's one-cycle lag.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b0;
      hs_pre      <= 1'b0;
      vs_pre      <= 1'b0;
      hsync       <= vga_pkg::sync_level(1'b0, SYNC_POL);
      vsync       <= vga_pkg::sync_level(1'b0, SYNC_POL);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      valid       <= h_act && v_act;
      hs_pre      <= h_sync_nxt;
      vs_pre      <= v_sync_nxt;
      hsync       <= vga_pkg::sync_level(hs_pre, SYNC_POL);
      vsync       <= vga_pkg::sync_level(vs_pre, SYNC_POL);
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign vga.h_cnt       = h_cnt;
  assign vga.v_cnt       = v_cnt;
  assign vga.VGAvalid    = valid;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;
  assign vga.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks on a 640x480 instance and a tiny 16x8 active-high instance
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst_a, en_a, rst_b, en_b;
  int   vectors = 0;
  int   miscompares = 0;

  vga_timing_if va ();
  vga_timing_if vb ();

  always #5 pclk = ~pclk;

  vga_timing_gen u_dut_a (
    .pclk (pclk),
    .rst  (rst_a),
    .en   (en_a),
    .vga  (va)
  );

  // Small frame: H 8/2/3/3 (total 16, hsync 10..12), V 4/1/2/1 (total 8, vsync 5..6).
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b1)
  ) u_dut_b (
    .pclk (pclk),
    .rst  (rst_b),
    .en   (en_b),
    .vga  (vb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    int valid_cnt, ls_cnt, fs_cnt, vs_cnt, vs_first;

    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b0;
    step(5);

    check("a_rst_h",      va.h_cnt, 0);
    check("a_rst_v",      va.v_cnt, 0);
    check("a_rst_valid",  va.VGAvalid, 0);
    check("a_rst_hsync",  va.hsync, 1);
    check("a_rst_vsync",  va.vsync, 1);
    check("a_rst_ls",     va.line_start, 0);
    check("a_rst_fs",     va.frame_start, 0);
    check("a_rst_fcnt",   va.frame_cnt, 0);
    check("b_rst_hsync",  vb.hsync, 0);
    check("b_rst_vsync",  vb.vsync, 0);

    rst_a = 1'b1;
    step(1);
    check("a_first_h",     va.h_cnt, 1);
    check("a_first_valid", va.VGAvalid, 1);

    // hsync window: asserted 657..752 (one cycle after 656..751)
    step(654);
    check("a_h655",        va.h_cnt, 655);
    check("a_hs_at_655",   va.hsync, 1);
    step(1);
    check("a_hs_at_656",   va.hsync, 1);
    step(1);
    check("a_hs_at_657",   va.hsync, 0);
    step(95);
    check("a_h752",        va.h_cnt, 752);
    check("a_hs_at_752",   va.hsync, 0);
    check("a_vs_line0",    va.vsync, 1);
    step(1);
    check("a_hs_at_753",   va.hsync, 1);
    step(47);
    check("a_wrap_h",      va.h_cnt, 0);
    check("a_wrap_v",      va.v_cnt, 1);
    check("a_wrap_ls",     va.line_start, 1);
    check("a_wrap_fs",     va.frame_start, 0);

    // One full line from (0,1): 640 visible samples, one line_start
    valid_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (va.VGAvalid) valid_cnt++;
      if (va.frame_start) fs_cnt++;
      if (va.line_start) begin
        ls_cnt++;
        check("a_ls_at_h0", va.h_cnt, 0);
      end
    end
    check("a_line_valid", valid_cnt, 640);
    check("a_line_ls",    ls_cnt, 1);
    check("a_line_fs",    fs_cnt, 0);
    check("a_line_h",     va.h_cnt, 0);
    check("a_line_v",     va.v_cnt, 2);

    // Enable gap at the last visible pixel
    step(639);
    check("a_pre_gap_h", va.h_cnt, 639);
    en_a = 1'b0;
    step(7);
    check("a_gap_h",     va.h_cnt, 639);
    check("a_gap_v",     va.v_cnt, 2);
    check("a_gap_valid", va.VGAvalid, 1);
    en_a = 1'b1;
    step(1);
    check("a_resume_h",     va.h_cnt, 640);
    check("a_resume_valid", va.VGAvalid, 0);

    // Small instance: one full frame of 128 cycles
    rst_b = 1'b1; en_b = 1'b1;
    vs_cnt = 0; fs_cnt = 0; vs_first = -1;
    for (int k = 1; k <= 128; k++) begin
      step(1);
      if (vb.vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
      end
      if (vb.frame_start) fs_cnt++;
    end
    check("b_vs_len",    vs_cnt, 32);
    check("b_vs_first",  vs_first, 81);
    check("b_frame_fs",  fs_cnt, 1);
    check("b_frame_end", vb.frame_start, 1);
    check("b_frame_cnt", vb.frame_cnt, 1);
    check("b_frame_h",   vb.h_cnt, 0);
    check("b_frame_v",   vb.v_cnt, 0);

    // Asynchronous reset between edges at (5,3)
    step(53);
    check("b_mid_h", vb.h_cnt, 5);
    check("b_mid_v", vb.v_cnt, 3);
    #2 rst_b = 1'b0;
    #1;
    check("b_async_h",    vb.h_cnt, 0);
    check("b_async_v",    vb.v_cnt, 0);
    check("b_async_fcnt", vb.frame_cnt, 0);
    check("b_async_vs",   vb.vsync, 0);
    step(1);
    rst_b = 1'b1;

    // frame_cnt wraps after 256 frames
    step(255 * 128);
    check("b_fcnt_255", vb.frame_cnt, 255);
    step(128);
    check("b_fcnt_wrap",  vb.frame_cnt, 0);
    check("b_wrap_fs",    vb.frame_start, 1);
    en_b = 1'b0;
    step(1);
    check("b_hold_fs",    vb.frame_start, 0);
    check("b_hold_ls",    vb.line_start, 0);
    check("b_hold_h",     vb.h_cnt, 0);
    check("b_hold_fcnt",  vb.frame_cnt, 0);
    en_b = 1'b1;
    step(1);
    check("b_resume_h",   vb.h_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
